// File: rtl/saq_fwd_pkg.sv
// Shared types and constants for the store address queue.
// Entry status flags and the address granularity used by the load search.
package saq_fwd_pkg;

  // Loads and stores are compared at word granularity; the low bits are byte offsets.
  localparam int unsigned ADDR_LSB = 2;

  typedef struct packed {
    logic a;  // entry allocated
    logic v;  // address valid
    logic d;  // store data ready
  } saq_flags_t;

  localparam saq_flags_t FLAGS_NEW = '{a: 1'b1, v: 1'b0, d: 1'b0};

endpackage

// File: rtl/saq_fwd_youngest_sel.sv
// Picks the youngest set bit of a match vector relative to the queue head:
// rotate so the head sits at bit 0, then priority-encode from the top.
module saq_fwd_youngest_sel #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 2**WIDTH
) (
  input  logic [SIZE-1:0]  match_i,
  input  logic [WIDTH-1:0] head_i,
  output logic             hit_o,
  output logic [WIDTH-1:0] idx_o
);

  logic [SIZE-1:0] rot;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rot   = '0;
    idx_o = '0;
    for (int r = 0; r < SIZE; r++) begin
      rot[r] = match_i[WIDTH'(head_i + WIDTH'(r))];
    end
    // Ascending scan: the last hit written is the one with the largest rel.
    for (int r = 0; r < SIZE; r++) begin
      if (rot[r]) idx_o = head_i + WIDTH'(r);
    end
  end

  assign hit_o = |match_i;

endmodule

// File: rtl/saq_fwd.sv
// Store address queue: in-order allocate/commit, branch-flush tail rollback and
// a combinational store-to-load search returning the youngest older overlapping store.
module saq_fwd
  import saq_fwd_pkg::*;
#(
  parameter int WIDTH_TAG  = 5,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH      = 4,
  parameter int SIZE       = 2**WIDTH,
  parameter int WIDTH_MASK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [WIDTH_TAG-1:0]  i_tag,
  output logic [WIDTH-1:0]      o_alloc_idx,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH:0]        o_count,
  input  logic                  i_weV,
  input  logic [WIDTH-1:0]      i_waddrV,
  input  logic [WIDTH_ADDR-1:0] i_addr,
  input  logic [WIDTH_MASK-1:0] i_mask,
  input  logic                  i_setD,
  input  logic [WIDTH-1:0]      i_waddrD,
  input  logic                  i_re,
  output logic                  o_head_rdy,
  output logic [WIDTH_ADDR-1:0] o_head_addr,
  output logic [WIDTH_MASK-1:0] o_head_mask,
  output logic [WIDTH_TAG-1:0]  o_head_tag,
  input  logic                  i_flush,
  input  logic [WIDTH:0]        i_flush_tail,
  input  logic                  i_ld_val,
  input  logic [WIDTH_ADDR-1:0] i_ld_addr,
  input  logic [WIDTH_MASK-1:0] i_ld_mask,
  input  logic [WIDTH:0]        i_ld_age,
  output logic                  o_ld_hit,
  output logic [WIDTH-1:0]      o_ld_idx,
  output logic                  o_ld_fwd,
  output logic                  o_ld_conflict
);

  typedef logic [WIDTH:0]   ptr_t;
  typedef logic [WIDTH-1:0] idx_t;

  ptr_t       head_q, head_d, tail_q, tail_d;
  saq_flags_t flags_q [SIZE];
  saq_flags_t flags_d [SIZE];

  logic [WIDTH_TAG-1:0]  tag_q  [SIZE];
  logic [WIDTH_ADDR-1:0] addr_q [SIZE];
  logic [WIDTH_MASK-1:0] mask_q [SIZE];

  idx_t head_idx, tail_idx;
  logic do_alloc, do_commit;
  ptr_t flush_span;

  assign head_idx   = head_q[WIDTH-1:0];
  assign tail_idx   = tail_q[WIDTH-1:0];
  assign o_empty    = (head_q == tail_q);
  assign o_full     = (head_idx == tail_idx) && (head_q[WIDTH] != tail_q[WIDTH]);
  assign o_count    = tail_q - head_q;
  assign o_alloc_idx = tail_idx;

  assign o_head_rdy  = flags_q[head_idx].a & flags_q[head_idx].v & flags_q[head_idx].d;
  assign o_head_addr = addr_q[head_idx];
  assign o_head_mask = mask_q[head_idx];
  assign o_head_tag  = tag_q[head_idx];

  // Full is judged on the current pointers, so a same-cycle commit never makes room.
  assign do_alloc   = i_we & ~o_full & ~i_flush;
  assign do_commit  = i_re & o_head_rdy;
  assign flush_span = tail_q - i_flush_tail;

  always_comb begin
    head_d = head_q + ptr_t'(do_commit);
    tail_d = i_flush ? i_flush_tail : tail_q + ptr_t'(do_alloc);
    for (int i = 0; i < SIZE; i++) begin
      idx_t rel_f;
      flags_d[i] = flags_q[i];
      rel_f      = idx_t'(i) - i_flush_tail[WIDTH-1:0];
      if (i_flush && ({1'b0, rel_f} < flush_span))        flags_d[i].a = 1'b0;
      if (do_commit && (idx_t'(i) == head_idx))           flags_d[i].a = 1'b0;
      if (do_alloc && (idx_t'(i) == tail_idx))            flags_d[i]   = FLAGS_NEW;
      if (flags_q[i].a && i_weV && (i_waddrV == idx_t'(i))) flags_d[i].v = 1'b1;
      if (flags_q[i].a && i_setD && (i_waddrD == idx_t'(i))) flags_d[i].d = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < SIZE; i++) flags_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < SIZE; i++) flags_q[i] <= flags_d[i];
    end
  end

  // NOTE: payload storage is not reset; every reader is gated by the A/V flags.
  always_ff @(posedge i_clk) begin
    if (do_alloc) tag_q[tail_idx] <= i_tag;
    if (i_weV && flags_q[i_waddrV].a) begin
      addr_q[i_waddrV] <= i_addr;
      mask_q[i_waddrV] <= i_mask;
    end
  end

  // Load search: window is the allocated entries older than the load's tail snapshot.
  ptr_t            age_rel;
  logic [SIZE-1:0] in_win, addr_known, match;
  logic            sel_hit;
  idx_t            sel_idx;
  logic            unused_ld_lsb;

  assign age_rel       = i_ld_age - head_q;
  assign unused_ld_lsb = ^i_ld_addr[ADDR_LSB-1:0];

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      idx_t rel;
      rel           = idx_t'(i) - head_idx;
      in_win[i]     = flags_q[i].a && ({1'b0, rel} < age_rel);
      addr_known[i] = flags_q[i].v;
      match[i]      = in_win[i] && flags_q[i].v
                   && (addr_q[i][WIDTH_ADDR-1:ADDR_LSB] == i_ld_addr[WIDTH_ADDR-1:ADDR_LSB])
                   && |(mask_q[i] & i_ld_mask);
    end
  end

  saq_fwd_youngest_sel #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_sel (
    .match_i (match),
    .head_i  (head_idx),
    .hit_o   (sel_hit),
    .idx_o   (sel_idx)
  );

  assign o_ld_hit      = i_ld_val & sel_hit;
  assign o_ld_idx      = o_ld_hit ? sel_idx : '0;
  assign o_ld_fwd      = o_ld_hit && ((mask_q[sel_idx] & i_ld_mask) == i_ld_mask)
                      && flags_q[sel_idx].d;
  assign o_ld_conflict = i_ld_val & |(in_win & ~addr_known);

  // A restored tail must lie between the current head and tail.
  ptr_t flush_rel, tail_rel;
  assign flush_rel = i_flush_tail - head_q;
  assign tail_rel  = tail_q - head_q;

  a_flush_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_flush |-> (flush_rel <= tail_rel));

endmodule

// File: tb/tb_saq_fwd.sv
// Self-checking bench for saq_fwd: scoreboard of allocated tags checked on commit,
// plus directed load-search, flush, wrap and asynchronous-reset scenarios.
module tb_saq_fwd;

  localparam int WT = 5, WA = 32, W = 4, S = 16, WM = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_we, i_weV, i_setD, i_re, i_flush, i_ld_val;
  logic [WT-1:0] i_tag;
  logic [W-1:0]  i_waddrV, i_waddrD;
  logic [WA-1:0] i_addr, i_ld_addr;
  logic [WM-1:0] i_mask, i_ld_mask;
  logic [W:0]    i_flush_tail, i_ld_age;
  logic [W-1:0]  o_alloc_idx, o_ld_idx;
  logic          o_full, o_empty, o_head_rdy, o_ld_hit, o_ld_fwd, o_ld_conflict;
  logic [W:0]    o_count;
  logic [WA-1:0] o_head_addr;
  logic [WM-1:0] o_head_mask;
  logic [WT-1:0] o_head_tag;

  always #5 i_clk = ~i_clk;

  saq_fwd #(.WIDTH_TAG(WT), .WIDTH_ADDR(WA), .WIDTH(W), .SIZE(S), .WIDTH_MASK(WM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_we), .i_tag(i_tag),
    .o_alloc_idx(o_alloc_idx), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .i_weV(i_weV), .i_waddrV(i_waddrV), .i_addr(i_addr), .i_mask(i_mask),
    .i_setD(i_setD), .i_waddrD(i_waddrD), .i_re(i_re), .o_head_rdy(o_head_rdy),
    .o_head_addr(o_head_addr), .o_head_mask(o_head_mask), .o_head_tag(o_head_tag),
    .i_flush(i_flush), .i_flush_tail(i_flush_tail), .i_ld_val(i_ld_val),
    .i_ld_addr(i_ld_addr), .i_ld_mask(i_ld_mask), .i_ld_age(i_ld_age),
    .o_ld_hit(o_ld_hit), .o_ld_idx(o_ld_idx), .o_ld_fwd(o_ld_fwd),
    .o_ld_conflict(o_ld_conflict)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [WT-1:0] sb_q [$];
  logic [WA-1:0] m_addr [S];
  logic [W:0]    m_head, m_tail;
  logic [WT-1:0] next_tag;
  logic [6:0]    ld_got;

  function automatic logic [W:0] model_count();
    logic [W:0] c;
    c = m_tail - m_head;
    return c;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_we = 0; i_tag = '0; i_weV = 0; i_waddrV = '0; i_addr = '0; i_mask = '0;
    i_setD = 0; i_waddrD = '0; i_re = 0; i_flush = 0; i_flush_tail = '0;
    i_ld_val = 0; i_ld_addr = '0; i_ld_mask = '0; i_ld_age = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    drive_idle();
    sb_q.delete();
    m_head = '0; m_tail = '0; next_tag = '0;
    #2;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc();
    i_we = 1; i_tag = next_tag;
    tick();
    i_we = 0;
    if (model_count() != (W+1)'(S)) begin
      sb_q.push_back(next_tag);
      m_tail = m_tail + 1'b1;
      next_tag = next_tag + 1'b1;
    end
  endtask

  task automatic wb(input int idx, input logic [WA-1:0] addr, input logic [WM-1:0] mask,
                    input logic set_d);
    i_weV = 1; i_waddrV = W'(idx); i_addr = addr; i_mask = mask;
    i_setD = set_d; i_waddrD = W'(idx);
    tick();
    i_weV = 0; i_setD = 0;
    m_addr[idx] = addr;
  endtask

  task automatic set_data(input int idx);
    i_setD = 1; i_waddrD = W'(idx);
    tick();
    i_setD = 0;
  endtask

  // Scoreboard pop: the head must carry the oldest outstanding tag and its written address.
  task automatic commit();
    logic [WT-1:0] exp_tag;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL commit_sb: scoreboard empty at commit");
    end else begin
      exp_tag = sb_q.pop_front();
      if (o_head_tag !== exp_tag) begin
        n_errors++;
        $display("FAIL commit_tag: got %0d expected %0d", o_head_tag, exp_tag);
      end
    end
    n_checks++;
    if ({o_head_rdy, o_head_addr} !== {1'b1, m_addr[m_head[W-1:0]]}) begin
      n_errors++;
      $display("FAIL commit_head: rdy=%0b addr=%h expected rdy=1 addr=%h",
               o_head_rdy, o_head_addr, m_addr[m_head[W-1:0]]);
    end
    i_re = 1;
    tick();
    i_re = 0;
    m_head = m_head + 1'b1;
  endtask

  task automatic ld(input logic [WA-1:0] addr, input logic [WM-1:0] mask, input logic [W:0] age);
    i_ld_val = 1; i_ld_addr = addr; i_ld_mask = mask; i_ld_age = age;
    #1;
    ld_got = {o_ld_hit, o_ld_idx, o_ld_fwd, o_ld_conflict};
  endtask

  task automatic check_ld(input string name, input logic [6:0] exp);
    n_checks++;
    if (ld_got !== exp) begin
      n_errors++;
      $display("FAIL %s: hit/idx/fwd/conf got %b_%b_%b_%b expected %b_%b_%b_%b", name,
               ld_got[6], ld_got[5:2], ld_got[1], ld_got[0], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_count(input string name, input logic [W:0] exp);
    n_checks++;
    if (o_count !== exp) begin
      n_errors++;
      $display("FAIL %s: count got %0d expected %0d", name, o_count, exp);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    #1;
    i_rst_n = 1'b0;
    i_ld_val = 1; i_ld_addr = '0; i_ld_mask = 4'hf; i_ld_age = 5'd5;
    #1;
    n_checks++;
    if ({o_empty, o_full, o_count, o_alloc_idx, o_head_rdy} !== {1'b1, 1'b0, 5'd0, 4'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_ctrl: empty=%0b full=%0b count=%0d alloc=%0d rdy=%0b expected 1 0 0 0 0",
               o_empty, o_full, o_count, o_alloc_idx, o_head_rdy);
    end
    ld_got = {o_ld_hit, o_ld_idx, o_ld_fwd, o_ld_conflict};
    check_ld("reset_ld", 7'b0);
    i_ld_val = 0;
    sb_q.delete();
    m_head = '0; m_tail = '0; next_tag = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < S; k++) alloc();
    n_checks++;
    if ({o_full, o_empty, o_alloc_idx} !== {1'b1, 1'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL full_16: full=%0b empty=%0b alloc=%0d expected 1 0 0", o_full, o_empty, o_alloc_idx);
    end
    check_count("count_16", 5'd16);
    alloc();
    check_count("drop_17th", 5'd16);
    wb(0, 32'h40, 4'hf, 1'b1);
    commit();
    check_count("count_after_commit", 5'd15);
    n_checks++;
    if ({o_full, o_alloc_idx} !== {1'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL refill_idx: full=%0b alloc=%0d expected 0 0", o_full, o_alloc_idx);
    end
    alloc();
    n_checks++;
    if ({o_full, o_count} !== {1'b1, 5'd16}) begin
      n_errors++;
      $display("FAIL refull: full=%0b count=%0d expected 1 16", o_full, o_count);
    end
    // Write and commit together while full: the write is not admitted.
    wb(1, 32'h44, 4'hf, 1'b1);
    i_we = 1; i_tag = next_tag;
    commit();
    i_we = 0;
    check_count("full_we_with_re", 5'd15);
  endtask

  task automatic test_commit();
    do_reset();
    for (int k = 0; k < 3; k++) alloc();
    wb(0, 32'h40, 4'hf, 1'b1);
    wb(1, 32'h100, 4'hf, 1'b0);
    commit();
    n_checks++;
    if (o_head_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL rdy_without_d: got %0b expected 0", o_head_rdy);
    end
    i_re = 1;
    tick();
    i_re = 0;
    check_count("re_not_ready", 5'd2);
    set_data(1);
    for (int k = 0; k < 8 && o_head_rdy !== 1'b1; k++) tick();
    n_checks++;
    if (o_head_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL head_addr: got %h expected 00000100", o_head_addr);
    end
    commit();
    check_count("after_commit_idx1", 5'd1);
  endtask

  task automatic test_forward();
    do_reset();
    for (int k = 0; k < 3; k++) alloc();
    wb(0, 32'h200, 4'hf, 1'b1);
    wb(2, 32'h200, 4'b0011, 1'b0);
    ld(32'h200, 4'b0001, 5'd3); check_ld("ld_age3",      {1'b1, 4'd2, 1'b0, 1'b1});
    ld(32'h200, 4'b0001, 5'd2); check_ld("ld_age2",      {1'b1, 4'd0, 1'b1, 1'b1});
    ld(32'h200, 4'b0001, 5'd1); check_ld("ld_age1",      {1'b1, 4'd0, 1'b1, 1'b0});
    ld(32'h204, 4'b0001, 5'd3); check_ld("ld_other_word", {1'b0, 4'd0, 1'b0, 1'b1});
    ld(32'h203, 4'b0100, 5'd3); check_ld("ld_no_overlap", {1'b1, 4'd0, 1'b1, 1'b1});
    i_ld_val = 0;
    #1;
    ld_got = {o_ld_hit, o_ld_idx, o_ld_fwd, o_ld_conflict};
    check_ld("ld_val_low", 7'b0);
    wb(1, 32'h200, 4'b1100, 1'b1);
    ld(32'h200, 4'b1100, 5'd3); check_ld("ld_v_and_d", {1'b1, 4'd1, 1'b1, 1'b0});
    i_ld_val = 0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 6; k++) alloc();
    i_flush = 1; i_flush_tail = 5'd3; i_we = 1; i_tag = 5'h1f;
    tick();
    i_flush = 0; i_we = 0;
    m_tail = 5'd3;
    for (int k = 0; k < 3; k++) void'(sb_q.pop_back());
    next_tag = 5'd6;
    n_checks++;
    if ({o_count, o_alloc_idx} !== {5'd3, 4'd3}) begin
      n_errors++;
      $display("FAIL flush_tail: count=%0d alloc=%0d expected 3 3", o_count, o_alloc_idx);
    end
    wb(4, 32'h400, 4'hf, 1'b1);
    check_count("wb_after_flush", 5'd3);
    ld(32'h400, 4'hf, 5'd6); check_ld("ld_flushed", {1'b0, 4'd0, 1'b0, 1'b1});
    i_ld_val = 0;
    for (int k = 0; k < 3; k++) wb(k, 32'h800 + 32'(k * 4), 4'hf, 1'b1);
    for (int k = 0; k < 3; k++) commit();
    n_checks++;
    if (o_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_drain_empty: got %0b expected 1", o_empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      alloc();
      wb(k, 32'h1000 + 32'(k * 4), 4'hf, 1'b1);
      commit();
    end
    for (int k = 0; k < 4; k++) alloc();
    wb(14, 32'h600, 4'hf, 1'b1);
    wb(15, 32'h500, 4'hf, 1'b1);
    wb(0,  32'h700, 4'hf, 1'b1);
    wb(1,  32'h500, 4'b0011, 1'b0);
    ld(32'h500, 4'b0001, 5'd18); check_ld("wrap_youngest", {1'b1, 4'd1,  1'b0, 1'b0});
    ld(32'h500, 4'b0001, 5'd17); check_ld("wrap_older",    {1'b1, 4'd15, 1'b1, 1'b0});
    i_ld_val = 0;
    commit();
    check_count("wrap_count", 5'd3);
  endtask

  task automatic test_async_reset();
    ld(32'h500, 4'b0001, 5'd18);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_empty, o_full, o_count, o_alloc_idx, o_head_rdy} !== {1'b1, 1'b0, 5'd0, 4'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset_ctrl: empty=%0b full=%0b count=%0d alloc=%0d rdy=%0b expected 1 0 0 0 0",
               o_empty, o_full, o_count, o_alloc_idx, o_head_rdy);
    end
    ld_got = {o_ld_hit, o_ld_idx, o_ld_fwd, o_ld_conflict};
    check_ld("async_reset_ld", 7'b0);
    drive_idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full();
    test_commit();
    test_forward();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
